neuron_controller: RTL and testbench

Sequencer that drives the combinational `neuron` datapath through one SNN time step. It latches an input spike vector, then walks every neuron in order. For each neuron it applies the leak once, and then integrates the weight of every active input, fetched from external weight memory. It writes each updated membrane potential back into an internal register file and collects the output spike vector. It sits between the Wishbone/CSR layer (start, parameters, results) and the `neuron` instance it drives.

---
 rtl/neuron_controller.sv | 196 +++++++++++++++++++
 tb/tb_neuron_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_controller.sv
// -----------------------------------------------------------------------------
// neuron_controller
//
// Sequencer that walks a combinational `neuron` datapath through one SNN time
// step. On an accepted start it latches the input spike vector, beta and v_th,
// then for every neuron n in order:
//   - applies the leak once (LEAK),
//   - scans the input lines one per cycle (SCAN) and, for each active line,
//     reads weight[n*NUM_INPUTS+i] from external memory and integrates it
//     (INTEG),
//   - advances to the next neuron (NEXT).
// Updated membrane potentials are written back into an internal register file
// and neuron spikes are ORed into the output spike vector.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               begin a time step (sampled in IDLE only)
//   mem_clear_i           zero all membrane potentials (IDLE only, start wins)
//   in_spikes_i           input spike vector, latched on accepted start
//   beta_i, v_th_i        leak factor / threshold, latched on accepted start
//   weight_rd_o           weight read strobe (data returns one cycle later)
//   weight_addr_o         weight address n*NUM_INPUTS+i
//   weight_data_i         weight read data
//   weight_o, v_mem_o,
//   beta_o, v_th_o,
//   function_sel_o        drive the neuron datapath (0 = leak, 1 = integrate)
//   spike_i, v_mem_i      neuron results
//   busy_o                high while a time step is in progress
//   done_o                one-cycle pulse at the end of a time step
//   spikes_o              output spikes of the last completed step
//   state_o               current FSM state, for observation only
//
// Handshake: there is no back-pressure anywhere. weight_rd_o is a one-cycle
// strobe issued in SCAN; weight_data_i must be valid in the very next cycle,
// which is always INTEG, where it is consumed combinationally.
// -----------------------------------------------------------------------------
module neuron_controller #(
   parameter int NUM_NEURONS = 10,
   parameter int NUM_INPUTS  = 16,
   parameter int ADDR_W      = $clog2(NUM_NEURONS*NUM_INPUTS)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic                   mem_clear_i,
   input  logic [NUM_INPUTS-1:0]  in_spikes_i,
   input  logic [7:0]             beta_i,
   input  logic [7:0]             v_th_i,
   output logic                   weight_rd_o,
   output logic [ADDR_W-1:0]      weight_addr_o,
   input  logic [7:0]             weight_data_i,
   output logic [7:0]             weight_o,
   output logic [7:0]             v_mem_o,
   output logic [7:0]             beta_o,
   output logic [7:0]             v_th_o,
   output logic                   function_sel_o,
   input  logic                   spike_i,
   input  logic [7:0]             v_mem_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [NUM_NEURONS-1:0] spikes_o,
   output logic [2:0]             state_o
);

   localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   // Input index must be able to hold NUM_INPUTS itself (end-of-scan marker).
   localparam int IW = $clog2(NUM_INPUTS + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEAK  = 3'd1,
      S_SCAN  = 3'd2,
      S_INTEG = 3'd3,
      S_NEXT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [NW-1:0]          r_n;
   logic [IW-1:0]          r_i;
   logic [NUM_INPUTS-1:0]  r_in_spikes;
   logic [7:0]             r_beta;
   logic [7:0]             r_v_th;
   logic [NUM_NEURONS-1:0] r_out_spikes;
   logic [7:0]             r_rf [NUM_NEURONS];

   logic                   w_scan_end;
   logic [NUM_INPUTS-1:0]  w_shifted;
   logic                   w_bit;
   logic                   w_last_n;
   logic [7:0]             w_cur_v;

   assign w_scan_end = (r_i == IW'(NUM_INPUTS));
   // Shift rather than index so r_i == NUM_INPUTS never addresses past the vector.
   assign w_shifted  = r_in_spikes >> r_i;
   assign w_bit      = w_shifted[0];
   assign w_last_n   = (r_n == NW'(NUM_NEURONS - 1));
   assign w_cur_v    = r_rf[r_n];

   assign beta_o   = r_beta;
   assign v_th_o   = r_v_th;
   assign spikes_o = r_out_spikes;
   assign busy_o   = (r_state != S_IDLE);
   assign state_o  = r_state;

   // State register and datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_n          <= '0;
         r_i          <= '0;
         r_in_spikes  <= '0;
         r_beta       <= '0;
         r_v_th       <= '0;
         r_out_spikes <= '0;
         for (int k = 0; k < NUM_NEURONS; k++) r_rf[k] <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_in_spikes  <= in_spikes_i;
                  r_beta       <= beta_i;
                  r_v_th       <= v_th_i;
                  r_out_spikes <= '0;
                  r_n          <= '0;
               end else if (mem_clear_i) begin
                  for (int k = 0; k < NUM_NEURONS; k++) r_rf[k] <= '0;
               end
            end
            S_LEAK: begin
               r_rf[r_n] <= v_mem_i;
               r_i       <= '0;
            end
            S_SCAN: begin
               // Inactive lines are skipped here; active ones advance in INTEG.
               if (!w_scan_end && !w_bit) r_i <= r_i + 1'b1;
            end
            S_INTEG: begin
               r_rf[r_n] <= v_mem_i;
               if (spike_i) r_out_spikes[r_n] <= 1'b1;
               r_i <= r_i + 1'b1;
            end
            S_NEXT: begin
               if (!w_last_n) r_n <= r_n + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Next-state and datapath drive.
   always_comb begin
      w_next_state   = r_state;
      weight_rd_o    = 1'b0;
      weight_addr_o  = '0;
      weight_o       = '0;
      v_mem_o        = '0;
      function_sel_o = 1'b0;
      done_o         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) w_next_state = S_LEAK;
         end
         S_LEAK: begin
            v_mem_o      = w_cur_v;
            w_next_state = S_SCAN;
         end
         S_SCAN: begin
            if (w_scan_end) begin
               w_next_state = S_NEXT;
            end else if (w_bit) begin
               weight_rd_o   = 1'b1;
               weight_addr_o = ADDR_W'(32'(r_n) * 32'(NUM_INPUTS) + 32'(r_i));
               w_next_state  = S_INTEG;
            end
         end
         S_INTEG: begin
            function_sel_o = 1'b1;
            weight_o       = weight_data_i;
            v_mem_o        = w_cur_v;
            w_next_state   = S_SCAN;
         end
         S_NEXT: begin
            w_next_state = w_last_n ? S_DONE : S_LEAK;
         end
         S_DONE: begin
            done_o       = 1'b1;
            w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_neuron_controller.sv
// -----------------------------------------------------------------------------
// tb_neuron_controller
//
// Drives neuron_controller (2 neurons x 4 inputs) with a stub neuron and a
// weight memory holding w[a] = a+1. Each time step is predicted by a reference
// model that evaluates the step arithmetically (per neuron: leak is identity,
// then add each active weight, spike and zero on reaching v_th), producing the
// expected read-address list, spike vector, membrane values and cycle count.
// -----------------------------------------------------------------------------
module tb_neuron_controller;

   localparam int N  = 2;
   localparam int NI = 4;
   localparam int AW = 3;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   logic          start_i     = 1'b0;
   logic          mem_clear_i = 1'b0;
   logic [NI-1:0] in_spikes_i = '0;
   logic [7:0]    beta_i      = '0;
   logic [7:0]    v_th_i      = '0;
   logic          weight_rd_o;
   logic [AW-1:0] weight_addr_o;
   logic [7:0]    weight_data_i = '0;
   logic [7:0]    weight_o;
   logic [7:0]    v_mem_o;
   logic [7:0]    beta_o;
   logic [7:0]    v_th_o;
   logic          function_sel_o;
   logic          spike_i;
   logic [7:0]    v_mem_i;
   logic          busy_o;
   logic          done_o;
   logic [N-1:0]  spikes_o;
   logic [2:0]    state_o;

   neuron_controller #(.NUM_NEURONS(N), .NUM_INPUTS(NI), .ADDR_W(AW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mem_clear_i(mem_clear_i),
      .in_spikes_i(in_spikes_i), .beta_i(beta_i), .v_th_i(v_th_i),
      .weight_rd_o(weight_rd_o), .weight_addr_o(weight_addr_o),
      .weight_data_i(weight_data_i), .weight_o(weight_o), .v_mem_o(v_mem_o),
      .beta_o(beta_o), .v_th_o(v_th_o), .function_sel_o(function_sel_o),
      .spike_i(spike_i), .v_mem_i(v_mem_i), .busy_o(busy_o), .done_o(done_o),
      .spikes_o(spikes_o), .state_o(state_o)
   );

   // ---------------- stub neuron ----------------
   logic [8:0] stub_sum;
   always_comb begin
      stub_sum = {1'b0, v_mem_o} + {1'b0, weight_o};
      spike_i  = 1'b0;
      v_mem_i  = v_mem_o;
      if (function_sel_o) begin
         if (stub_sum >= {1'b0, v_th_o}) begin
            spike_i = 1'b1;
            v_mem_i = 8'd0;
         end else begin
            v_mem_i = stub_sum[7:0];
         end
      end
   end

   // ---------------- weight memory, one-cycle read latency ----------------
   always_ff @(posedge clk_i) begin
      if (weight_rd_o) weight_data_i <= {5'b0, weight_addr_o} + 8'd1;
   end

   // Observed read addresses.
   logic [AW-1:0] rd_q[$];
   always @(negedge clk_i) begin
      if (weight_rd_o) rd_q.push_back(weight_addr_o);
   end

   // ---------------- scoreboard / model ----------------
   logic [AW-1:0] exp_q[$];
   int            m_rf [N];
   logic [N-1:0]  m_spk;
   int            m_cyc;
   int            total = 0;
   int            bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic [NI-1:0] sp, input logic [7:0] vth);
      int a;
      int s;
      m_spk = '0;
      exp_q.delete();
      for (int n = 0; n < N; n++) begin
         for (int i = 0; i < NI; i++) begin
            if (sp[i]) begin
               a = n * NI + i;
               exp_q.push_back(AW'(a));
               s = m_rf[n] + a + 1;
               if (s >= int'(vth)) begin
                  m_rf[n]  = 0;
                  m_spk[n] = 1'b1;
               end else begin
                  m_rf[n] = s;
               end
            end
         end
      end
      m_cyc = N * (NI + 3) + N * $countones(sp) + 1;
   endtask

   task automatic check_rf(input string tag);
      for (int k = 0; k < N; k++)
         check($sformatf("%s_rf%0d", tag, k), 32'(dut.r_rf[k]), 32'(m_rf[k]));
   endtask

   // ---------------- driver tasks ----------------
   task automatic run_step(input logic [NI-1:0] sp, input logic [7:0] beta,
                           input logic [7:0] vth, input logic clr_too,
                           input logic glitch);
      int n;
      model_step(sp, vth);
      rd_q.delete();
      @(posedge clk_i); #1;
      start_i     = 1'b1;
      mem_clear_i = clr_too;
      in_spikes_i = sp;
      beta_i      = beta;
      v_th_i      = vth;
      @(posedge clk_i); #1;
      start_i     = 1'b0;
      mem_clear_i = 1'b0;
      check("busy_at_start", busy_o, 1'b1);
      check("beta_latched", beta_o, beta);
      check("vth_latched", v_th_o, vth);
      check("spikes_cleared", spikes_o, '0);
      n = 1;
      while (!done_o && n < 400) begin
         @(posedge clk_i); #1;
         n++;
         if (glitch) begin
            // A start while busy must be ignored; different inputs would show.
            start_i     = (n == 3);
            in_spikes_i = ~sp;
            v_th_i      = ~vth;
         end
      end
      start_i = 1'b0;
      check("cycles_to_done", n, m_cyc);
      check("spikes_o", spikes_o, m_spk);
      check("vth_held", v_th_o, vth);
      check("read_count", rd_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < rd_q.size(); k++)
         check($sformatf("read_addr%0d", k), rd_q[k], exp_q[k]);
      check_rf("step");
      @(posedge clk_i); #1;
      check("done_pulse_width", done_o, 1'b0);
      check("busy_after_done", busy_o, 1'b0);
      check("spikes_hold", spikes_o, m_spk);
   endtask

   task automatic do_clear();
      @(posedge clk_i); #1;
      mem_clear_i = 1'b1;
      @(posedge clk_i); #1;
      mem_clear_i = 1'b0;
      for (int k = 0; k < N; k++) m_rf[k] = 0;
      check("clear_no_busy", busy_o, 1'b0);
      check_rf("clear");
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int w;
      logic [NI-1:0] r_sp;
      logic [7:0]    r_vth;
      logic [7:0]    r_beta;
      for (int k = 0; k < N; k++) m_rf[k] = 0;

      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      check("rst_busy", busy_o, 1'b0);
      check("rst_done", done_o, 1'b0);
      check("rst_rd", weight_rd_o, 1'b0);
      check("rst_fsel", function_sel_o, 1'b0);
      check("rst_addr", weight_addr_o, '0);
      check("rst_weight", weight_o, '0);
      check("rst_vmem", v_mem_o, '0);
      check("rst_beta", beta_o, '0);
      check("rst_vth", v_th_o, '0);
      check("rst_spikes", spikes_o, '0);
      check_rf("rst");

      // Leak only: no weight reads.
      run_step(4'b0000, 8'h10, 8'd50, 1'b0, 1'b0);
      // Two active inputs, accumulated over 18 steps; neuron 1 eventually fires.
      run_step(4'b0101, 8'h20, 8'd200, 1'b0, 1'b0);
      for (int s = 0; s < 17; s++)
         run_step(4'b0101, 8'h20, 8'd200, 1'b0, (s == 5));
      // Threshold 1: every integrate fires.
      run_step(4'b1111, 8'h30, 8'd1, 1'b0, 1'b0);
      // Nonzero step, clear, then a leak-only step.
      run_step(4'b0011, 8'h40, 8'd200, 1'b0, 1'b0);
      do_clear();
      run_step(4'b0000, 8'h40, 8'd200, 1'b0, 1'b0);
      // Start and clear together: start wins, potentials carry over.
      run_step(4'b0110, 8'h50, 8'd200, 1'b0, 1'b0);
      run_step(4'b0110, 8'h50, 8'd200, 1'b1, 1'b0);

      // Reset during INTEG of neuron 1.
      @(posedge clk_i); #1;
      start_i     = 1'b1;
      in_spikes_i = 4'b1111;
      v_th_i      = 8'd200;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      w = 0;
      while (!(weight_rd_o && weight_addr_o >= AW'(NI)) && w < 200) begin
         @(posedge clk_i); #1;
         w++;
      end
      check("reach_n1_read", (w < 200), 1'b1);
      @(posedge clk_i); #1;
      check("in_integ", function_sel_o, 1'b1);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      for (int k = 0; k < N; k++) m_rf[k] = 0;
      check("midrst_busy", busy_o, 1'b0);
      check("midrst_done", done_o, 1'b0);
      check("midrst_spikes", spikes_o, '0);
      check("midrst_vth", v_th_o, '0);
      check_rf("midrst");
      run_step(4'b0101, 8'h11, 8'd200, 1'b0, 1'b0);

      // Randomized steps.
      for (int r = 0; r < 24; r++) begin
         r_sp   = NI'($urandom_range(0, 15));
         r_vth  = 8'($urandom_range(1, 255));
         r_beta = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) do_clear();
         run_step(r_sp, r_beta, r_vth, ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
